dst4_row_seq: RTL

//  Upstream sequencer for the 4-tap MAC in the DST datapath. Accepts one 4-sample block
//  (valid/ready) and steps the 4 rows of the 4-point DST-VII matrix through one mac_4,
//  one row per cycle. Each row result is rounded, shifted and saturated. The 4 results

---
 rtl/dst_pkg.sv | 33 +++
 rtl/dst4_row_seq_mac_4.sv | 19 +
 rtl/dst4_row_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/dst_pkg.sv
// Shared definitions for the DST-VII row sequencer: coefficient table, FSM
// states and the round/saturate helper applied to each row sum.
package dst_pkg;

  localparam int DST4_COEFF [0:3][0:3] = '{
    '{29,  55,  74,  84},
    '{74,  74,   0, -74},
    '{84, -29, -74,  55},
    '{55, -84,  74, -29}
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Round half toward +inf, arithmetic right shift, clamp to a res_w-bit signed range.
  // 64-bit working width keeps the rounding add free of overflow for any sane y.
  function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] y,
                                                 input int shift,
                                                 input int res_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (y + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (res_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (res_w - 1));
    if (r > hi)      rnd_sat = hi;
    else if (r < lo) rnd_sat = lo;
    else             rnd_sat = r;
  endfunction

endpackage

// File: rtl/dst4_row_seq_mac_4.sv
// Combinational 4-tap signed multiply-accumulate: y = sum x[i]*c[i].
module mac_4 #(
  parameter int IN_W    = 12,
  parameter int COEFF_W = 8,
  parameter int OUT_W   = IN_W + COEFF_W + 2
) (
  input  logic [0:3][IN_W-1:0]    x,
  input  logic [0:3][COEFF_W-1:0] c,
  output logic signed [OUT_W-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < 4; i++) begin
      y = y + OUT_W'($signed(x[i])) * OUT_W'($signed(c[i]));
    end
  end

endmodule

// File: rtl/dst4_row_seq.sv
// Steps one captured 4-sample block through the 4 DST-VII rows on a single
// mac_4, one row per accepted output slot, emitting rounded/saturated results.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// RUN   | row k of xbuf is on the MAC; loads the output register when it is free
module dst4_row_seq
  import dst_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int COEFF_W = 8,
  parameter int OUT_W   = IN_W + COEFF_W + 2,
  parameter int SHIFT   = 7,
  parameter int RES_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:3][IN_W-1:0] in_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_W-1:0]     out_data,
  output logic [1:0]           out_idx,
  output logic                 out_last
);

  state_t                   state;
  state_t                   state_nxt;
  logic [1:0]               k;
  logic [0:3][IN_W-1:0]     xbuf;
  logic [0:3][COEFF_W-1:0]  coeff;
  logic signed [OUT_W-1:0]  y;
  logic                     load;
  logic                     run_load;
  logic                     blk_end;
  logic                     accept;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      coeff[j] = COEFF_W'(DST4_COEFF[k][j]);
    end
  end

  mac_4 #(
    .IN_W    (IN_W),
    .COEFF_W (COEFF_W),
    .OUT_W   (OUT_W)
  ) u_mac (
    .x (xbuf),
    .c (coeff),
    .y (y)
  );

  // The last row's load frees the block buffer, so the next block can be taken
  // in the same cycle; this keeps back-to-back blocks free of bubbles.
  assign load     = !out_valid || out_ready;
  assign run_load = (state == RUN) && load;
  assign blk_end  = run_load && (k == 2'd3);
  assign in_ready = !rst && ((state == IDLE) || blk_end);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (blk_end && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= 2'd0;
      xbuf      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
    end else begin
      if (accept) xbuf <= in_x;
      // k wraps 3->0 on the last row, which also serves a same-cycle new block
      if (run_load)    k <= k + 2'd1;
      else if (accept) k <= 2'd0;
      if (run_load) begin
        out_data  <= RES_W'(rnd_sat(64'(y), SHIFT, RES_W));
        out_idx   <= k;
        out_last  <= (k == 2'd3);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
